// File: rtl/ld_req_issuer.sv
// ld_req_issuer: serialises one load request into the FTk token stream.
// Optional nack-stall counter is enabled by defining LD_REQ_STALL_COUNT_EN.
package ld_req_pkg;
  localparam int WIDTH_DATA = 32;
  typedef struct packed {
    logic                  v;
    logic                  a;
    logic                  r;
    logic                  c;
    logic                  i;
    logic [WIDTH_DATA-1:0] d;
  } FTk_t;
  typedef struct packed {
    logic n;
    logic t;
  } BTk_t;
endpackage

module ld_req_issuer
  import ld_req_pkg::*;
#(
  parameter int WIDTH_ADDR   = 8,
  parameter int WIDTH_LENGTH = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    I_Start,
  input  logic [WIDTH_DATA-1:0]   I_MyID,
  input  logic [WIDTH_DATA-1:0]   I_ID_T,
  input  logic [WIDTH_DATA-1:0]   I_ID_F,
  input  logic [WIDTH_DATA-1:0]   I_AttribWord,
  input  logic [WIDTH_DATA-1:0]   I_RConfig,
  input  logic [WIDTH_LENGTH+1:0] I_Length,
  input  logic [WIDTH_ADDR-1:0]   I_Stride,
  input  logic [WIDTH_ADDR-1:0]   I_Base,
  output FTk_t                    O_FTk,
  input  BTk_t                    I_BTk,
  output logic                    O_Ack,
  output logic                    O_Busy,
  output logic                    O_Done,
  output logic [15:0]             O_StallCount
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_TERM} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              idx_q, idx_d, idx_nxt;
  FTk_t                    ftk_q, ftk_d, nxt_word;
  logic                    ack_q, ack_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [WIDTH_DATA-1:0]   id_t_q, id_t_d;
  logic [WIDTH_DATA-1:0]   id_f_q, id_f_d;
  logic [WIDTH_DATA-1:0]   attr_q, attr_d;
  logic [WIDTH_DATA-1:0]   rcfg_q, rcfg_d;
  logic [WIDTH_LENGTH+1:0] len_q, len_d;
  logic [WIDTH_ADDR-1:0]   stride_q, stride_d;
  logic [WIDTH_ADDR-1:0]   base_q, base_d;
  logic [WIDTH_DATA-1:0]   myid_q, myid_d;

  assign idx_nxt = idx_q + 4'd1;

  // Build the word that follows the one currently presented.
  always_comb begin
    nxt_word   = '0;
    nxt_word.v = 1'b1;
    unique case (idx_nxt)
      4'd1:    nxt_word.d = id_t_q;
      4'd2:    nxt_word.d = id_f_q;
      4'd3:    nxt_word.d = attr_q;
      4'd4:    nxt_word.d = rcfg_q;
      4'd5:    nxt_word.d = WIDTH_DATA'(len_q);
      4'd6:    nxt_word.d = WIDTH_DATA'(stride_q);
      4'd7:    nxt_word.d = WIDTH_DATA'(base_q);
      default: nxt_word.r = 1'b1;
    endcase
  end

  // Next-state: accept, stream with nack hold, abort or wait for termination.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    ftk_d    = ftk_q;
    ack_d    = 1'b0;
    done_d   = 1'b0;
    myid_d   = myid_q;
    id_t_d   = id_t_q;
    id_f_d   = id_f_q;
    attr_d   = attr_q;
    rcfg_d   = rcfg_q;
    len_d    = len_q;
    stride_d = stride_q;
    base_d   = base_q;
    unique case (state_q)
      IDLE: begin
        // A start in the O_Done cycle is held off by one cycle.
        if (I_Start && !done_q) begin
          myid_d   = I_MyID;
          id_t_d   = I_ID_T;
          id_f_d   = I_ID_F;
          attr_d   = I_AttribWord;
          rcfg_d   = I_RConfig;
          len_d    = I_Length;
          stride_d = I_Stride;
          base_d   = I_Base;
          ack_d    = 1'b1;
          idx_d    = 4'd0;
          ftk_d    = '0;
          ftk_d.v  = 1'b1;
          ftk_d.a  = 1'b1;
          ftk_d.d  = I_MyID;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (I_BTk.t) begin
          ftk_d   = '0;
          idx_d   = 4'd0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (ftk_q.v && !I_BTk.n) begin
          if (idx_q >= 4'd8) begin
            ftk_d   = '0;
            state_d = WAIT_TERM;
          end else begin
            idx_d = idx_nxt;
            ftk_d = nxt_word;
          end
        end
      end
      WAIT_TERM: begin
        if (I_BTk.t) begin
          idx_d   = 4'd0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, stream and holding registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      ftk_q    <= '0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      myid_q   <= '0;
      id_t_q   <= '0;
      id_f_q   <= '0;
      attr_q   <= '0;
      rcfg_q   <= '0;
      len_q    <= '0;
      stride_q <= '0;
      base_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      ftk_q    <= ftk_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      myid_q   <= myid_d;
      id_t_q   <= id_t_d;
      id_f_q   <= id_f_d;
      attr_q   <= attr_d;
      rcfg_q   <= rcfg_d;
      len_q    <= len_d;
      stride_q <= stride_d;
      base_q   <= base_d;
    end
  end

  assign O_FTk  = ftk_q;
  assign O_Ack  = ack_q;
  assign O_Busy = busy_q;
  assign O_Done = done_q;

`ifdef LD_REQ_STALL_COUNT_EN
  logic [15:0] stall_q, stall_d;

  // Count cycles a valid word is held by nack; restart on acceptance.
  always_comb begin
    stall_d = stall_q;
    if (ack_d) begin
      stall_d = '0;
    end else if (ftk_q.v && I_BTk.n && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign O_StallCount = stall_q;
`else
  assign O_StallCount = '0;
`endif

endmodule

// File: tb/tb_ld_req_issuer.sv
// tb_ld_req_issuer: directed and random requests against a word-list model.
// Stall counter expectations follow LD_REQ_STALL_COUNT_EN.
module tb_ld_req_issuer;
  import ld_req_pkg::*;

  typedef struct packed {
    logic [31:0] myid, idt, idf, attr, rcfg;
    logic [9:0]  len;
    logic [7:0]  stride, base;
  } req_t;

  logic        clock = 1'b0;
  logic        rst = 1'b0;
  logic        st = 1'b0;
  req_t        cur = '0;
  BTk_t        btk = '0;
  FTk_t        ftk;
  logic        ack, busy, done;
  logic [15:0] stall;
  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;

  ld_req_issuer dut (
    .clock        (clock),
    .reset        (rst),
    .I_Start      (st),
    .I_MyID       (cur.myid),
    .I_ID_T       (cur.idt),
    .I_ID_F       (cur.idf),
    .I_AttribWord (cur.attr),
    .I_RConfig    (cur.rcfg),
    .I_Length     (cur.len),
    .I_Stride     (cur.stride),
    .I_Base       (cur.base),
    .O_FTk        (ftk),
    .I_BTk        (btk),
    .O_Ack        (ack),
    .O_Busy       (busy),
    .O_Done       (done),
    .O_StallCount (stall)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int exp_stall(input int s);
`ifdef LD_REQ_STALL_COUNT_EN
    return s;
`else
    return 0;
`endif
  endfunction

  function automatic req_t rnd_req();
    req_t r;
    r.myid   = $urandom;
    r.idt    = $urandom;
    r.idf    = $urandom;
    r.attr   = $urandom;
    r.rcfg   = $urandom;
    r.len    = 10'($urandom);
    r.stride = 8'($urandom);
    r.base   = 8'($urandom);
    return r;
  endfunction

  function automatic FTk_t mkword(input req_t r, input int j);
    FTk_t w;
    w   = '0;
    w.v = 1'b1;
    case (j)
      0: begin w.a = 1'b1; w.d = r.myid; end
      1: w.d = r.idt;
      2: w.d = r.idf;
      3: w.d = r.attr;
      4: w.d = r.rcfg;
      5: w.d = {22'd0, r.len};
      6: w.d = {24'd0, r.stride};
      7: w.d = {24'd0, r.base};
      default: w.r = 1'b1;
    endcase
    return w;
  endfunction

  // Done was just observed; a start right now must not be acknowledged.
  task automatic after_done();
    st = 1'b1;
    tick();
    st = 1'b0;
    chk("ack_held_after_done", 64'(ack), 64'd0);
    chk("idle_after_done", 64'(busy), 64'd0);
  endtask

  task automatic run_req(input req_t r, input logic [31:0] nmask,
                         input int pct, input int abort_k, input int gap,
                         input int busy_cyc);
    FTk_t exp[9];
    int   k, stalls, cyc;
    logic nk, ab;
    for (int j = 0; j < 9; j++) exp[j] = mkword(r, j);
    cur = r;
    st  = 1'b1;
    tick();
    st  = 1'b0;
    cyc = 1;
    chk("ack", 64'(ack), 64'd1);
    chk("stall_clear", 64'(stall), 64'd0);
    k = 0;
    stalls = 0;
    while (k < 9 && cyc < 300) begin
      chk("word", 64'(ftk), 64'(exp[k]));
      chk("busy", 64'(busy), 64'd1);
      if (cyc > 1) chk("no_ack", 64'(ack), 64'd0);
      nk = ((cyc < 32) && nmask[cyc]) || ($urandom_range(99) < pct);
      ab = (k == abort_k);
      btk.n = nk;
      btk.t = ab;
      if (cyc == busy_cyc) begin
        st  = 1'b1;
        cur = rnd_req();
      end
      tick();
      st = 1'b0;
      btk = '0;
      cyc++;
      if (ab) begin
        chk("abort_ftk", 64'(ftk), 64'd0);
        chk("abort_done", 64'(done), 64'd1);
        chk("abort_busy", 64'(busy), 64'd0);
        after_done();
        return;
      end
      if (nk) stalls++;
      else k++;
    end
    chk("stream_end", 64'(k), 64'd9);
    chk("release_timing", 64'(cyc), 64'(10 + stalls));
    chk("stall_count", 64'(stall), 64'(exp_stall(stalls)));
    for (int g = 0; g < gap; g++) begin
      chk("wait_ftk", 64'(ftk), 64'd0);
      chk("wait_busy", 64'(busy), 64'd1);
      btk.n = 1'($urandom);
      tick();
    end
    btk = '0;
    chk("stall_hold", 64'(stall), 64'(exp_stall(stalls)));
    chk("no_done_early", 64'(done), 64'd0);
    btk.t = 1'b1;
    tick();
    btk.t = 1'b0;
    chk("done", 64'(done), 64'd1);
    chk("done_busy", 64'(busy), 64'd0);
    chk("done_ftk", 64'(ftk), 64'd0);
    after_done();
  endtask

  initial begin
    req_t r;
    int   a;
    rst = 1'b0;
    tick();
    tick();
    chk("rst_ftk", 64'(ftk), 64'd0);
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    rst = 1'b1;
    tick();

    r = '{myid: 32'h11, idt: 32'h22, idf: 32'h33, attr: 32'h44,
          rcfg: 32'h55, len: 10'h3F, stride: 8'h01, base: 8'h10};
    run_req(r, 32'd0, 0, -1, 2, 0);
    run_req(r, 32'h70, 0, -1, 2, 0);
    run_req(rnd_req(), 32'd0, 0, 5, 0, 0);
    run_req(rnd_req(), 32'd0, 0, -1, 1, 5);

    cur = rnd_req();
    st  = 1'b1;
    tick();
    st  = 1'b0;
    tick();
    tick();
    tick();
    chk("pre_rst_word3", 64'(ftk), 64'(mkword(cur, 3)));
    #2 rst = 1'b0;
    #1;
    chk("arst_ftk", 64'(ftk), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_ack", 64'(ack), 64'd0);
    tick();
    rst = 1'b1;
    tick();
    run_req(rnd_req(), 32'd0, 0, -1, 0, 0);

    r = rnd_req();
    r.len  = '1;
    r.base = 8'hFF;
    run_req(r, 32'h6, 0, -1, 1, 0);

    for (int n = 0; n < 20; n++) begin
      a = $urandom_range(0, 15);
      run_req(rnd_req(), 32'd0, 30, (a <= 8) ? a : -1,
              $urandom_range(0, 4), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ld_req_issuer.md
# ld_req_issuer

Request-path transmitter for the CRAM load unit's front-end. Serialises one load request into the FTk token stream that the load front-end parses. The stream is an acquire message carrying My-ID, then ID_T, ID_F, attribute word, R-config, length, stride and base, then a release. The block honours BTk nack back-pressure and waits for the termination token before it accepts the next request. It sits between a tile-level requester (or test sequencer) and the load unit's I_FTk/O_BTk pair.

## Interface
- WIDTH_ADDR, 8, width of stride and base fields
- WIDTH_LENGTH, 8, access length is WIDTH_LENGTH+2 bits
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- I_Start  in  1  request pulse; sampled only in IDLE
- I_MyID / I_ID_T / I_ID_F  in  WIDTH_DATA each  IDs to transmit
- I_AttribWord  in  WIDTH_DATA  attribute word
- I_RConfig  in  WIDTH_DATA  R-config word
- I_Length  in  WIDTH_LENGTH+2  access length
- I_Stride / I_Base  in  WIDTH_ADDR each  stride factor, base address
- O_FTk  out  FTk_t  token stream to the load front-end
- I_BTk  in  BTk_t  back-token from the load front-end (n = nack, t = termination)
- O_Ack  out  1  one-cycle pulse: request accepted and fields latched
- O_Busy  out  1  high from acceptance until termination is seen
- O_Done  out  1  one-cycle pulse on termination
- O_StallCount  out  16  nack-stall cycles (macro-dependent)

## Operation
- FSM states: IDLE, SEND, WAIT_TERM.
- IDLE:
  - I_Start=1 latches all I_* fields into holding registers and raises O_Ack.
  - Loads word index 0 and moves to SEND.
- SEND: O_FTk is registered and presents the word selected by index:
  - 0: v=1, a=1, r=0, d=MyID (acquire message)
  - 1: ID_T
  - 2: ID_F
  - 3: AttribWord
  - 4: RConfig
  - 5: Length, zero-extended
  - 6: Stride, zero-extended
  - 7: Base, zero-extended
  - 8: release, v=1, a=0, r=1, d=0
  - Words 1–7 have v=1, a=0, r=0.
  - Every word has c=0 and i=0.
- Advance rule: the presented word is consumed in any cycle where O_FTk.v=1 and I_BTk.n=0.
  - While I_BTk.n=1, O_FTk holds every field stable and the index holds.
- After the release word is consumed, O_FTk is 0 and the FSM moves to WAIT_TERM.
- WAIT_TERM: on I_BTk.t=1, pulse O_Done and return to IDLE.
- I_BTk.t=1 during SEND: abort.
  - The current word is withdrawn (O_FTk is 0 next cycle).
  - O_Done pulses and the FSM returns to IDLE. No release word is sent.
- I_Start while not IDLE: ignored. No O_Ack; holding registers are unchanged.
- O_Busy = (state != IDLE).
- The index counter is 4 bits and saturates at 8; it never wraps.

## Timing
- Reset (reset=0, asynchronous): state IDLE, index 0, O_FTk all zero, O_Ack=0, O_Busy=0, O_Done=0, O_StallCount=0, holding registers zero.
- Reset asserted mid-stream truncates the stream immediately; there is no release word.
- Cycle numbering, no back-pressure:
  - I_Start high at cycle 0; O_Ack=1 at cycle 1.
  - Word k is on O_FTk in cycle 1+k, so the release word is in cycle 9.
  - O_FTk.v=0 from cycle 10.
- Each cycle of I_BTk.n=1 while O_FTk.v=1 delays all later words by exactly one cycle.
- O_Done is asserted in the cycle after I_BTk.t is sampled.
  - The earliest next O_Ack is 2 cycles after O_Done rises.
- Combinational paths from I_BTk to O_FTk: none. All outputs are registered.

## Configuration
- LD_REQ_STALL_COUNT_EN defined:
  - O_StallCount increments on each cycle with O_FTk.v=1 and I_BTk.n=1.
  - Saturates at 16'hFFFF; clears on O_Ack.
- Undefined: O_StallCount is tied to 0 and the counter logic is absent. Stream behaviour is identical.

## Test plan
- Basic request, no back-pressure:
  - Stimulus: MyID=0x11, ID_T=0x22, ID_F=0x33, Attrib=0x44, RConfig=0x55, Length=0x3F, Stride=1, Base=0x10, I_Start at cycle 0, I_BTk.t at cycle 12.
  - Response: the nine words in cycles 1–9, acquire flag only on word 0, release flag only on word 8; O_Done in cycle 13.
- Back-pressure: hold I_BTk.n=1 for cycles 4–6.
  - Response: O_FTk frozen on Attrib 0x44 during cycles 4–6, release word in cycle 12; O_StallCount=3 with the macro, 0 without.
- Abort: I_BTk.t=1 while the Length word is presented.
  - Response: O_FTk.v=0 next cycle, O_Done pulse, no release word, O_Busy=0.
- Start while busy: second I_Start at cycle 5.
  - Response: no O_Ack and the stream is unchanged. A later I_Start in IDLE is accepted normally.
- Asynchronous reset: reset=0 mid-cycle during word 3.
  - Response: O_FTk=0 and O_Busy=0 without waiting for a clock edge. The first request after release starts cleanly at word 0.
- Width boundary: Length=all-ones (WIDTH_LENGTH+2 bits), Base=0xFF.
  - Response: upper d bits of both words are zero.
